// File: rtl/ttl_74259_addr_latch_sync_if.sv
// Bus bundle for the synchronous 74259 addressable latch: control/data in, latched outputs back.
interface ttl_74259_addr_latch_sync_if #(
  parameter int unsigned OUTPUTS = 8
);
  localparam int unsigned ADDR_W = $clog2(OUTPUTS);

  logic              Clear_bar;
  logic              Enable_bar;
  logic [ADDR_W-1:0] Address;
  logic              D;
  logic [OUTPUTS-1:0] Q;
  logic              Wr_pulse;

  modport master (
    output Clear_bar, Enable_bar, Address, D,
    input  Q, Wr_pulse
  );

  modport slave (
    input  Clear_bar, Enable_bar, Address, D,
    output Q, Wr_pulse
  );
endinterface

// File: rtl/ttl_74259_addr_latch_sync.sv
// Synchronous 74LS259 model: steers one data bit into one of OUTPUTS registered
// latch bits (addressable latch), or acts as a 1-of-N demux / clear when Clear_bar is low.
module ttl_74259_addr_latch_sync #(
  parameter int unsigned        OUTPUTS     = 8,
  parameter logic [OUTPUTS-1:0] RESET_VALUE = '0,
  parameter bit                 STROBE_MODE = 1'b0
) (
  input logic                         Clk,
  input logic                         RST_n,
  ttl_74259_addr_latch_sync_if.slave  bus
);

  logic [OUTPUTS-1:0] q_r;
  logic               wr_pulse_r;
  logic               en_prev_r;

  logic [OUTPUTS-1:0] q_next_c;
  logic [OUTPUTS-1:0] sel_c;
  logic               act_c;
  logic               wr_next_c;

  // Write qualifier, one-hot target mask and next latch contents.
  // An out-of-range address shifts the single 1 off the top, leaving an empty mask,
  // so the write is dropped without a separate range compare.
  always_comb begin
    act_c     = 1'b0;
    sel_c     = '0;
    q_next_c  = q_r;
    wr_next_c = 1'b0;

    if (STROBE_MODE) begin
      act_c = !bus.Enable_bar && en_prev_r;
    end else begin
      act_c = !bus.Enable_bar;
    end

    if (act_c) begin
      sel_c = OUTPUTS'(1) << bus.Address;
    end

    if (bus.Clear_bar) begin
      q_next_c  = (q_r & ~sel_c) | (sel_c & {OUTPUTS{bus.D}});
      wr_next_c = act_c;
    end else begin
      q_next_c  = sel_c & {OUTPUTS{bus.D}};
      wr_next_c = 1'b1;
    end
  end

  // State register: latch bits, write pulse and Enable_bar history.
  always_ff @(posedge Clk or negedge RST_n) begin
    if (!RST_n) begin
      q_r        <= RESET_VALUE;
      wr_pulse_r <= 1'b0;
      en_prev_r  <= 1'b1;
    end else begin
      q_r        <= q_next_c;
      wr_pulse_r <= wr_next_c;
      en_prev_r  <= bus.Enable_bar;
    end
  end

  assign bus.Q        = q_r;
  assign bus.Wr_pulse = wr_pulse_r;

endmodule

// File: tb/tb_ttl_74259_addr_latch_sync.sv
// Directed bench for the synchronous 74259: level mode (8 outputs), strobe mode
// (8 outputs) and a non-power-of-2 instance (6 outputs, non-zero reset value).
module tb_ttl_74259_addr_latch_sync;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  ttl_74259_addr_latch_sync_if #(.OUTPUTS(8)) bus_lvl ();
  ttl_74259_addr_latch_sync_if #(.OUTPUTS(8)) bus_stb ();
  ttl_74259_addr_latch_sync_if #(.OUTPUTS(6)) bus_six ();

  ttl_74259_addr_latch_sync #(.OUTPUTS(8), .RESET_VALUE(8'h00), .STROBE_MODE(1'b0)) u_lvl (
    .Clk(clk), .RST_n(rst_n), .bus(bus_lvl)
  );
  ttl_74259_addr_latch_sync #(.OUTPUTS(8), .RESET_VALUE(8'h00), .STROBE_MODE(1'b1)) u_stb (
    .Clk(clk), .RST_n(rst_n), .bus(bus_stb)
  );
  ttl_74259_addr_latch_sync #(.OUTPUTS(6), .RESET_VALUE(6'h2A), .STROBE_MODE(1'b0)) u_six (
    .Clk(clk), .RST_n(rst_n), .bus(bus_six)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lvl(input logic clr_b, input logic en_b, input logic [2:0] a, input logic d);
    bus_lvl.Clear_bar = clr_b; bus_lvl.Enable_bar = en_b; bus_lvl.Address = a; bus_lvl.D = d;
  endtask

  task automatic drive_stb(input logic clr_b, input logic en_b, input logic [2:0] a, input logic d);
    bus_stb.Clear_bar = clr_b; bus_stb.Enable_bar = en_b; bus_stb.Address = a; bus_stb.D = d;
  endtask

  task automatic drive_six(input logic clr_b, input logic en_b, input logic [2:0] a, input logic d);
    bus_six.Clear_bar = clr_b; bus_six.Enable_bar = en_b; bus_six.Address = a; bus_six.D = d;
  endtask

  initial begin
    int pulses;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive_lvl(1'b1, 1'b1, 3'd0, 1'b0);
    drive_stb(1'b1, 1'b1, 3'd0, 1'b0);
    drive_six(1'b1, 1'b1, 3'd0, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    check("rst_q_lvl", 16'(bus_lvl.Q), 16'h00);
    check("rst_wr_lvl", 16'(bus_lvl.Wr_pulse), 16'h0);
    check("rst_q_six", 16'(bus_six.Q), 16'h2A);

    // Level-mode latch writes
    drive_lvl(1'b1, 1'b0, 3'd3, 1'b1); tick();
    check("latch_a3", 16'(bus_lvl.Q), 16'h08);
    check("latch_a3_wr", 16'(bus_lvl.Wr_pulse), 16'h1);
    drive_lvl(1'b1, 1'b0, 3'd5, 1'b1); tick();
    check("latch_a5", 16'(bus_lvl.Q), 16'h28);
    drive_lvl(1'b1, 1'b1, 3'd1, 1'b0); tick();
    check("hold_q", 16'(bus_lvl.Q), 16'h28);
    check("hold_wr", 16'(bus_lvl.Wr_pulse), 16'h0);
    drive_lvl(1'b1, 1'b1, 3'd5, 1'b0); tick();
    check("hold_q2", 16'(bus_lvl.Q), 16'h28);
    drive_lvl(1'b1, 1'b0, 3'd5, 1'b0); tick();
    check("latch_d0", 16'(bus_lvl.Q), 16'h08);

    // Fill to FF, then demux
    for (int i = 0; i < 8; i++) begin
      drive_lvl(1'b1, 1'b0, 3'(i), 1'b1); tick();
    end
    check("fill_ff", 16'(bus_lvl.Q), 16'hFF);
    drive_lvl(1'b0, 1'b0, 3'd6, 1'b1); tick();
    check("demux_a6", 16'(bus_lvl.Q), 16'h40);
    check("demux_wr", 16'(bus_lvl.Wr_pulse), 16'h1);
    drive_lvl(1'b1, 1'b1, 3'd6, 1'b1); tick();
    check("demux_wr_drop", 16'(bus_lvl.Wr_pulse), 16'h0);
    check("demux_hold", 16'(bus_lvl.Q), 16'h40);

    // Build A5 then clear
    drive_lvl(1'b0, 1'b0, 3'd0, 1'b1); tick();
    drive_lvl(1'b1, 1'b0, 3'd2, 1'b1); tick();
    drive_lvl(1'b1, 1'b0, 3'd5, 1'b1); tick();
    drive_lvl(1'b1, 1'b0, 3'd7, 1'b1); tick();
    check("build_a5", 16'(bus_lvl.Q), 16'hA5);
    drive_lvl(1'b0, 1'b1, 3'd7, 1'b1); tick();
    check("clear_q", 16'(bus_lvl.Q), 16'h00);
    check("clear_wr", 16'(bus_lvl.Wr_pulse), 16'h1);
    drive_lvl(1'b1, 1'b1, 3'd7, 1'b1); tick();
    check("clear_hold", 16'(bus_lvl.Q), 16'h00);
    check("clear_wr_drop", 16'(bus_lvl.Wr_pulse), 16'h0);

    // Asynchronous reset mid-cycle, no clock edge in between
    drive_lvl(1'b1, 1'b0, 3'd3, 1'b1); tick();
    drive_lvl(1'b1, 1'b1, 3'd3, 1'b1);
    check("pre_rst_q", 16'(bus_lvl.Q), 16'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_q", 16'(bus_lvl.Q), 16'h00);
    check("async_rst_wr", 16'(bus_lvl.Wr_pulse), 16'h0);
    #1;
    rst_n = 1'b1;
    tick();

    // Strobe mode: Enable_bar held low while Address steps 0..3
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      drive_stb(1'b1, 1'b0, 3'(i), 1'b1); tick();
      if (bus_stb.Wr_pulse) pulses++;
    end
    check("strobe_q", 16'(bus_stb.Q), 16'h01);
    check("strobe_pulses", 16'(pulses), 16'd1);
    drive_stb(1'b1, 1'b1, 3'd2, 1'b1); tick();
    check("strobe_idle_wr", 16'(bus_stb.Wr_pulse), 16'h0);
    drive_stb(1'b1, 1'b0, 3'd2, 1'b1); tick();
    check("strobe_a2", 16'(bus_stb.Q), 16'h05);
    check("strobe_a2_wr", 16'(bus_stb.Wr_pulse), 16'h1);
    drive_stb(1'b0, 1'b0, 3'd2, 1'b1); tick();
    check("strobe_held_clear", 16'(bus_stb.Q), 16'h00);
    check("strobe_held_clear_wr", 16'(bus_stb.Wr_pulse), 16'h1);
    drive_stb(1'b1, 1'b1, 3'd0, 1'b0); tick();

    // Six outputs: out-of-range address
    check("six_rst_again", 16'(bus_six.Q), 16'h2A);
    drive_six(1'b1, 1'b0, 3'd7, 1'b1); tick();
    check("six_oor_latch7", 16'(bus_six.Q), 16'h2A);
    drive_six(1'b1, 1'b0, 3'd6, 1'b1); tick();
    check("six_oor_latch6", 16'(bus_six.Q), 16'h2A);
    drive_six(1'b0, 1'b0, 3'd7, 1'b1); tick();
    check("six_oor_demux", 16'(bus_six.Q), 16'h00);
    drive_six(1'b1, 1'b0, 3'd5, 1'b1); tick();
    check("six_latch5", 16'(bus_six.Q), 16'h20);
    drive_six(1'b1, 1'b1, 3'd0, 1'b0); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
